cache_verify_monitor: RTL and testbench

//  Synthesisable run monitor for cache self-test. Parametrised successor of the single-cache

---
 rtl/cache_verify_pkg.sv | 21 ++
 rtl/cache_verify_lane.sv | 76 +++++++
 rtl/cache_verify_monitor.sv | 171 +++++++++++++++++
 tb/tb_cache_verify_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_verify_pkg.sv
// Shared definitions for the cache self-test run monitor.
//   fail_code_t : failure codes reported on fail_code (0 none .. 4 timeout)
//   state_t     : run-monitor state machine encoding
package cache_verify_pkg;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_REPLACE  = 3'd1,
        FC_CACHERES = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_TIMEOUT  = 3'd4
    } fail_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/cache_verify_lane.sv
// One cache test channel of the run monitor.
// The lane tracks the next expected round index and whether the last index
// has been completed, and classifies this cycle's inputs into a fail code.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          start of a new run: expected index and done flag restart
//   run            monitor is in RUN; inputs are ignored otherwise
//   round_finish   round completed, with its index on test_index
//   replace_wrong  replacement check failed
//   cacheres_wrong read data mismatch
//   exp_index      next expected round index
//   done           last index already completed
//   done_next      done as it will be after this edge
//   accept         this cycle's round_finish is in order and counted
//   code           this cycle's failure code (FC_NONE when clean)
module cache_verify_lane
    import cache_verify_pkg::*;
#(
    parameter int unsigned          IDX_W      = 8,
    parameter logic [IDX_W-1:0]     LAST_INDEX = {IDX_W{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic             round_finish,
    input  logic [IDX_W-1:0] test_index,
    input  logic             replace_wrong,
    input  logic             cacheres_wrong,
    output logic [IDX_W-1:0] exp_index,
    output logic             done,
    output logic             done_next,
    output logic             accept,
    output logic [2:0]       code
);

    fail_code_t lane_code;
    logic       in_order;

    // A finish always takes priority over the other two checks, so the
    // error pulses are only looked at when no round completed this cycle.
    always_comb begin
        in_order  = !done && (test_index == exp_index);
        accept    = run && round_finish && in_order;
        done_next = done || (accept && (test_index == LAST_INDEX));
        lane_code = FC_NONE;
        if (run) begin
            if (round_finish) begin
                if (!in_order) begin
                    lane_code = FC_SEQUENCE;
                end
            end else if (replace_wrong) begin
                lane_code = FC_REPLACE;
            end else if (cacheres_wrong) begin
                lane_code = FC_CACHERES;
            end
        end
    end

    assign code = lane_code;

    // The expected index stops at LAST_INDEX; completion is held in done.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            exp_index <= '0;
            done      <= 1'b0;
        end else if (accept) begin
            if (test_index == LAST_INDEX) begin
                done <= 1'b1;
            end else begin
                exp_index <= exp_index + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_verify_monitor.sv
// Run monitor for cache self-test over NUM_CH parallel test channels.
// Checks per-channel round index order, replace/read-data failures and a
// no-progress watchdog, and captures the first failure (code, channel, index).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          pulse: clear results and begin a run (ignored in RUN)
//   round_finish   per channel: round completed
//   test_index     per channel index, channel c at [c*IDX_W +: IDX_W]
//   replace_wrong  per channel: replacement check failed
//   cacheres_wrong per channel: read data mismatch
//   activity       per channel: cache handshake seen this cycle
//   busy           run in progress
//   pass           sticky: every channel completed LAST_INDEX cleanly
//   fail           sticky: a failure was captured
//   fail_code      0 none, 1 replace, 2 cacheres, 3 sequence, 4 timeout
//   fail_ch        channel of the captured failure
//   fail_index     offending test_index, or expected index on timeout
//   rounds_done    accepted rounds over all channels, saturating
module cache_verify_monitor
    import cache_verify_pkg::*;
#(
    parameter int unsigned      NUM_CH     = 1,
    parameter int unsigned      IDX_W      = 8,
    parameter logic [IDX_W-1:0] LAST_INDEX = {IDX_W{1'b1}},
    parameter int unsigned      TIMEOUT    = 65535,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       round_finish,
    input  logic [NUM_CH*IDX_W-1:0] test_index,
    input  logic [NUM_CH-1:0]       replace_wrong,
    input  logic [NUM_CH-1:0]       cacheres_wrong,
    input  logic [NUM_CH-1:0]       activity,
    output logic                    busy,
    output logic                    pass,
    output logic                    fail,
    output logic [2:0]              fail_code,
    output logic [2:0]              fail_ch,
    output logic [IDX_W-1:0]        fail_index,
    output logic [CNT_W-1:0]        rounds_done
);

    state_t             state, state_next;
    logic               run, clear;
    logic [NUM_CH-1:0]  ch_done, ch_done_next, ch_accept;
    logic [IDX_W-1:0]   ch_exp  [NUM_CH];
    logic [2:0]         ch_code [NUM_CH];

    logic               ch_fail;
    logic [2:0]         sel_ch, sel_code;
    logic [IDX_W-1:0]   sel_index;
    logic [2:0]         to_ch;
    logic [IDX_W-1:0]   to_index;

    logic [CNT_W-1:0]   wd;
    logic               any_act, timeout;
    logic [3:0]         accept_cnt;
    logic [CNT_W:0]     rounds_sum;

    assign run   = (state == ST_RUN);
    assign clear = start && !run;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        cache_verify_lane #(
            .IDX_W      (IDX_W),
            .LAST_INDEX (LAST_INDEX)
        ) u_lane (
            .clk            (clk),
            .reset          (reset),
            .clear          (clear),
            .run            (run),
            .round_finish   (round_finish[c]),
            .test_index     (test_index[c*IDX_W +: IDX_W]),
            .replace_wrong  (replace_wrong[c]),
            .cacheres_wrong (cacheres_wrong[c]),
            .exp_index      (ch_exp[c]),
            .done           (ch_done[c]),
            .done_next      (ch_done_next[c]),
            .accept         (ch_accept[c]),
            .code           (ch_code[c])
        );
    end

    // Lowest failing channel, lowest not-done channel, and accepted rounds.
    always_comb begin
        ch_fail    = 1'b0;
        sel_ch     = '0;
        sel_code   = FC_NONE;
        sel_index  = '0;
        to_ch      = '0;
        to_index   = '0;
        accept_cnt = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!ch_fail && (ch_code[c] != FC_NONE)) begin
                ch_fail   = 1'b1;
                sel_ch    = 3'(c);
                sel_code  = ch_code[c];
                sel_index = test_index[c*IDX_W +: IDX_W];
            end
            accept_cnt = accept_cnt + 4'(ch_accept[c]);
        end
        for (int unsigned c = NUM_CH; c > 0; c--) begin
            if (!ch_done[c-1]) begin
                to_ch    = 3'(c-1);
                to_index = ch_exp[c-1];
            end
        end
    end

    assign any_act    = (|activity) || (|round_finish);
    assign timeout    = run && !any_act && (wd == CNT_W'(TIMEOUT - 1));
    assign rounds_sum = {1'b0, rounds_done} + (CNT_W+1)'(accept_cnt);

    // A failure in the completing cycle wins over the pass.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (ch_fail || timeout) begin
                    state_next = ST_FAIL;
                end else if (&ch_done_next) begin
                    state_next = ST_PASS;
                end
            end
            default: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wd          <= '0;
            fail_code   <= '0;
            fail_ch     <= '0;
            fail_index  <= '0;
            rounds_done <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                wd          <= '0;
                fail_code   <= '0;
                fail_ch     <= '0;
                fail_index  <= '0;
                rounds_done <= '0;
            end else if (run) begin
                wd          <= any_act ? '0 : wd + 1'b1;
                rounds_done <= rounds_sum[CNT_W] ? '1 : rounds_sum[CNT_W-1:0];
                if (ch_fail) begin
                    fail_code  <= sel_code;
                    fail_ch    <= sel_ch;
                    fail_index <= sel_index;
                end else if (timeout) begin
                    fail_code  <= FC_TIMEOUT;
                    fail_ch    <= to_ch;
                    fail_index <= to_index;
                end
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign pass = (state == ST_PASS);
    assign fail = (state == ST_FAIL);

endmodule

// File: tb/tb_cache_verify_monitor.sv
// Bench for cache_verify_monitor with 4 channels, 8-bit index, last index
// 255, watchdog 16 cycles and a 10-bit round counter (so a full run saturates).
module tb_cache_verify_monitor;

    localparam int NCH   = 4;
    localparam int IW    = 8;
    localparam int LAST  = 255;
    localparam int TMO   = 16;
    localparam int CW    = 10;
    localparam int RMAX  = (1 << CW) - 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [NCH-1:0]   rf;
    logic [NCH*IW-1:0] ti;
    logic [NCH-1:0]   rw;
    logic [NCH-1:0]   cw;
    logic [NCH-1:0]   act;
    logic             busy, pass, fail;
    logic [2:0]       fail_code, fail_ch;
    logic [IW-1:0]    fail_index;
    logic [CW-1:0]    rounds_done;

    cache_verify_monitor #(
        .NUM_CH     (NCH),
        .IDX_W      (IW),
        .LAST_INDEX (8'hff),
        .TIMEOUT    (TMO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .round_finish   (rf),
        .test_index     (ti),
        .replace_wrong  (rw),
        .cacheres_wrong (cw),
        .activity       (act),
        .busy           (busy),
        .pass           (pass),
        .fail           (fail),
        .fail_code      (fail_code),
        .fail_ch        (fail_ch),
        .fail_index     (fail_index),
        .rounds_done    (rounds_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit m_run, m_pass, m_fail;
    int m_code, m_ch, m_idx, m_rounds, m_idle;
    int m_exp [NCH];
    bit m_done [NCH];

    task automatic chk(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_code = 0; m_ch = 0; m_idx = 0;
        m_rounds = 0; m_idle = 0;
        for (int c = 0; c < NCH; c++) begin
            m_exp[c] = 0;
            m_done[c] = 0;
        end
    endtask

    // Effect of the coming clock edge given the inputs currently driven.
    task automatic model_step();
        int first, fcode, fidx, acc, idx, cand;
        int nexp [NCH];
        bit ndone [NCH];
        bit all_done;
        if (reset) begin
            model_clear();
            m_run = 0;
        end else if (!m_run) begin
            if (start) begin
                model_clear();
                m_run = 1;
            end
        end else begin
            first = -1; fcode = 0; fidx = 0; acc = 0;
            for (int c = 0; c < NCH; c++) begin
                idx = int'(ti[c*IW +: IW]);
                cand = 0;
                nexp[c] = m_exp[c];
                ndone[c] = m_done[c];
                if (rf[c]) begin
                    if (m_done[c] || idx != m_exp[c]) cand = 3;
                    else begin
                        acc++;
                        if (idx == LAST) ndone[c] = 1;
                        else nexp[c] = m_exp[c] + 1;
                    end
                end else if (rw[c]) cand = 1;
                else if (cw[c]) cand = 2;
                if (cand != 0 && first < 0) begin
                    first = c; fcode = cand; fidx = idx;
                end
            end
            m_rounds = (m_rounds + acc > RMAX) ? RMAX : m_rounds + acc;
            if (rf != 0 || act != 0) m_idle = 0;
            else m_idle++;
            all_done = 1;
            for (int c = 0; c < NCH; c++) if (!ndone[c]) all_done = 0;
            if (first >= 0) begin
                m_run = 0; m_fail = 1; m_code = fcode; m_ch = first; m_idx = fidx;
            end else if (m_idle == TMO) begin
                m_run = 0; m_fail = 1; m_code = 4;
                for (int c = NCH - 1; c >= 0; c--) begin
                    if (!m_done[c]) begin
                        m_ch = c; m_idx = m_exp[c];
                    end
                end
            end else if (all_done) begin
                m_run = 0; m_pass = 1;
            end
            for (int c = 0; c < NCH; c++) begin
                m_exp[c] = nexp[c];
                m_done[c] = ndone[c];
            end
        end
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; rf = '0; ti = '0; rw = '0; cw = '0; act = '0;
    endtask

    // One clock: model, edge, then compare every output against the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("busy", int'(busy), int'(m_run));
        chk("pass", int'(pass), int'(m_pass));
        chk("fail", int'(fail), int'(m_fail));
        chk("fail_code", int'(fail_code), m_code);
        chk("fail_ch", int'(fail_ch), m_ch);
        chk("fail_index", int'(fail_index), m_idx);
        chk("rounds_done", int'(rounds_done), m_rounds);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1;
        tick();
        start = 0;
    endtask

    // All channels step through 0..LAST in lockstep.
    task automatic full_run();
        do_start();
        for (int i = 0; i <= LAST; i++) begin
            rf = '1;
            ti = {NCH{8'(i)}};
            act = 4'($urandom);
            tick();
            if (i == 199) chk("t1_rounds_mid", int'(rounds_done), 800);
            if (i == LAST - 1) begin
                chk("t1_not_yet_pass", int'(pass), 0);
                chk("t1_busy_mid", int'(busy), 1);
            end
        end
        chk("t1_pass", int'(pass), 1);
        chk("t1_fail", int'(fail), 0);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_rounds_sat", int'(rounds_done), RMAX);
        idle_inputs();
        rw = '1;
        tick();
        chk("t1_pass_sticky", int'(pass), 1);
        chk("t1_code_none", int'(fail_code), 0);
    endtask

    typedef struct {
        bit [NCH-1:0]    rf;
        bit [NCH*IW-1:0] ti;
        bit [NCH-1:0]    rw;
        bit [NCH-1:0]    cw;
        int              e_fail;
        int              e_code;
        int              e_ch;
        int              e_idx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // ti packs {ch3, ch2, ch1, ch0}
        vecs[0] = '{4'b0000, 32'h0000_0500, 4'b0000, 4'b0010, 1, 2, 1, 5};
        vecs[1] = '{4'b0001, 32'h0022_0000, 4'b0101, 4'b0000, 1, 1, 2, 8'h22};
        vecs[2] = '{4'b0010, 32'h0000_0700, 4'b0000, 4'b0000, 1, 3, 1, 7};
        vecs[3] = '{4'b0000, 32'h0000_0900, 4'b1000, 4'b0010, 1, 2, 1, 9};
        vecs[4] = '{4'b0100, 32'h0000_0000, 4'b0000, 4'b0100, 0, 0, 0, 0};
        vecs[5] = '{4'b1111, 32'h0000_0000, 4'b0001, 4'b1000, 0, 0, 0, 0};
        vecs[6] = '{4'b1001, 32'h0100_4400, 4'b0010, 4'b0000, 1, 1, 1, 8'h44};

        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_rounds", int'(rounds_done), 0);
        tick();
        chk("idle_stays", int'(busy), 0);

        // T1: clean full run, saturating round count
        full_run();

        // Single-cycle classification vectors
        for (int v = 0; v < 7; v++) begin
            do_reset();
            do_start();
            rf = vecs[v].rf; ti = vecs[v].ti; rw = vecs[v].rw; cw = vecs[v].cw;
            tick();
            chk($sformatf("vec%0d_fail", v), int'(fail), vecs[v].e_fail);
            chk($sformatf("vec%0d_code", v), int'(fail_code), vecs[v].e_code);
            chk($sformatf("vec%0d_ch", v), int'(fail_ch), vecs[v].e_ch);
            chk($sformatf("vec%0d_idx", v), int'(fail_index), vecs[v].e_idx);
        end

        // T3a: out-of-order index
        do_reset();
        do_start();
        for (int i = 0; i < 2; i++) begin
            rf = 4'b0001; ti = 32'(i);
            tick();
        end
        rf = 4'b0001; ti = 32'h3;
        tick();
        chk("t3_code", int'(fail_code), 3);
        chk("t3_ch", int'(fail_ch), 0);
        chk("t3_idx", int'(fail_index), 3);

        // T3b: finish after the channel is done
        do_start();
        for (int i = 0; i <= LAST; i++) begin
            idle_inputs();
            rf = 4'b1000; ti = {8'(i), 24'h0};
            tick();
        end
        chk("t3b_ch_done_no_pass", int'(pass), 0);
        rf = 4'b1000; ti = {8'hff, 24'h0};
        tick();
        chk("t3b_code", int'(fail_code), 3);
        chk("t3b_ch", int'(fail_ch), 3);
        chk("t3b_idx", int'(fail_index), 255);

        // T4: watchdog right after start
        do_start();
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t4_no_fail_yet", int'(fail), 0);
        tick();
        chk("t4_fail", int'(fail), 1);
        chk("t4_code", int'(fail_code), 4);
        chk("t4_ch", int'(fail_ch), 0);
        chk("t4_idx", int'(fail_index), 0);

        // T4b: watchdog after progress reports the expected index
        do_start();
        for (int i = 0; i < 2; i++) begin
            rf = 4'b0001; ti = 32'(i);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t4b_no_fail_yet", int'(fail), 0);
        tick();
        chk("t4b_code", int'(fail_code), 4);
        chk("t4b_idx", int'(fail_index), 2);

        // T6: reset mid-run, then a clean rerun
        do_start();
        for (int i = 0; i < 10; i++) begin
            rf = '1; ti = {NCH{8'(i)}};
            tick();
        end
        do_reset();
        chk("t6_busy", int'(busy), 0);
        chk("t6_rounds", int'(rounds_done), 0);
        chk("t6_fail", int'(fail), 0);
        full_run();

        // Randomised runs against the model
        for (int r = 0; r < 30; r++) begin
            bit quiet;
            quiet = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) do_reset();
            do_start();
            for (int k = 0; k < 300; k++) begin
                idle_inputs();
                if ($urandom_range(0, 199) == 0) start = 1;
                if ($urandom_range(0, 499) == 0) reset = 1;
                for (int c = 0; c < NCH; c++) begin
                    int p;
                    int idx;
                    p = $urandom_range(0, 999);
                    idx = m_exp[c];
                    if (p < 10) begin
                        rf[c] = 1;
                        idx = m_exp[c] ^ (1 << $urandom_range(0, 7));
                    end else if (p < (quiet ? 30 : 600) && !m_done[c]) begin
                        rf[c] = 1;
                    end
                    ti[c*IW +: IW] = 8'(idx);
                    rw[c] = ($urandom_range(0, 299) == 0);
                    cw[c] = ($urandom_range(0, 299) == 0);
                    act[c] = ($urandom_range(0, 99) < (quiet ? 2 : 30));
                end
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
